// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front end driving an 8-bit ALU with a 4-entry register file
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int REG_N = 4,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_rd,
  input  logic [IDX_W-1:0]  cmd_rs1,
  input  logic [IDX_W-1:0]  cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic              flag_mismatch,
  output logic [CNT_W-1:0]  op_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state;
  logic [DATA_W-1:0] rf [REG_N];
  logic [IDX_W-1:0] rd_q;
  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP) && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
      rd_q <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_opcode <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_illegal <= 1'b0;
      flag_mismatch <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_load) begin
            rf[cmd_rd] <= cmd_imm;
            rsp_data <= cmd_imm;
            rsp_zero <= (cmd_imm == '0);
            rsp_illegal <= 1'b0;
            state <= RESP;
          end else begin
            alu_a <= rf[cmd_rs1];
            alu_b <= rf[cmd_rs2];
            alu_opcode <= cmd_op;
            rd_q <= cmd_rd;
            rsp_illegal <= (cmd_op >= 3'd5);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          rf[rd_q] <= alu_out;
          rsp_data <= alu_out;
          rsp_zero <= alu_zero;
          flag_mismatch <= flag_mismatch | (alu_zero != (alu_out == '0));
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          op_count <= &op_count ? op_count : op_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed scoreboard bench with a behavioural ALU and register-file model
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_load = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [7:0] cmd_imm = '0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_opcode;
  logic alu_zero;
  logic rsp_valid, rsp_ready = 1'b0, rsp_zero, rsp_illegal, flag_mismatch;
  logic [7:0] rsp_data;
  logic [15:0] op_count;
  logic bad_zero = 1'b0;
  typedef struct packed {logic [7:0] d; logic z; logic il;} rsp_t;
  rsp_t sb[$];
  logic [7:0] m_rf [4];
  int m_cnt = 0;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_illegal(rsp_illegal), .flag_mismatch(flag_mismatch), .op_count(op_count)
  );
  always_comb begin
    alu_out = 8'h00;
    case (alu_opcode)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = ~alu_a;
      default: alu_out = 8'h00;
    endcase
    alu_zero = !bad_zero && (alu_out == 8'h00);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_cnt = 0;
  endtask
  task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] imm);
    int n;
    logic [7:0] a, b, r;
    logic z;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_timeout", n < 50, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    a = m_rf[rs1];
    b = m_rf[rs2];
    if (ld) r = imm;
    else case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~a;
      default: r = 8'h00;
    endcase
    z = (!ld && bad_zero) ? 1'b0 : (r == 8'h00);
    m_rf[rd] = r;
    sb.push_back('{d: r, z: z, il: !ld && op >= 3'd5});
  endtask
  task automatic wait_rsp(input string tag, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    chk({tag, "_latency"}, n, lat);
  endtask
  task automatic check_rsp(input string tag);
    rsp_t e;
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, rsp_data, e.d);
      chk({tag, "_zero"}, rsp_zero, e.z);
      chk({tag, "_illegal"}, rsp_illegal, e.il);
    end
  endtask
  task automatic ack(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    if (m_cnt < 16'hFFFF) m_cnt++;
    @(negedge clk);
    chk({tag, "_op_count"}, op_count, m_cnt);
    chk({tag, "_valid_drop"}, rsp_valid, 0);
  endtask
  task automatic run(input string tag, input logic ld, input logic [2:0] op, input logic [1:0] rd,
                     input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
    send(ld, op, rd, rs1, rs2, imm);
    wait_rsp(tag, ld ? 1 : 2);
    check_rsp(tag);
    ack(tag);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_flag", flag_mismatch, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    run("ld_r0", 1, 0, 0, 0, 0, 8'h3C);
    run("ld_r1", 1, 0, 1, 0, 0, 8'hC4);
    run("add_wrap", 0, 3'd0, 2, 0, 1, 0);
    chk("t1_op_count", op_count, 3);
    run("ld_r0b", 1, 0, 0, 0, 0, 8'h05);
    run("ld_r1b", 1, 0, 1, 0, 0, 8'h07);
    run("sub", 0, 3'd1, 2, 0, 1, 0);
    run("and", 0, 3'd2, 3, 2, 1, 0);
    run("or", 0, 3'd3, 3, 0, 1, 0);
    run("not", 0, 3'd4, 0, 0, 0, 0);
    run("same_reg", 0, 3'd0, 1, 1, 1, 0);
    run("illegal", 0, 3'd6, 3, 1, 0, 0);
    run("rd_after_ill", 0, 3'd3, 2, 3, 3, 0);
    chk("ill_flag", flag_mismatch, 0);
    send(1, 0, 2, 0, 0, 8'h5A);
    wait_rsp("stall", 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_rd = 2'd3; cmd_imm = 8'hFF;
      end else cmd_valid = 1'b0;
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 8'h5A);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_op_count", op_count, m_cnt);
    end
    cmd_valid = 1'b0;
    check_rsp("stall");
    ack("stall");
    run("r3_kept", 0, 3'd3, 0, 3, 3, 0);
    send(0, 3'd0, 1, 0, 2, 0);
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_sb_empty", sb.size(), 0);
    run("clr_r0", 0, 3'd0, 0, 0, 0, 0);
    run("clr_r23", 0, 3'd3, 1, 2, 3, 0);
    run("clr_r1", 0, 3'd0, 1, 1, 1, 0);
    bad_zero = 1'b1;
    run("bad_zero", 0, 3'd0, 0, 0, 1, 0);
    bad_zero = 1'b0;
    chk("flag_set", flag_mismatch, 1);
    run("flag_hold_cmd", 1, 0, 2, 0, 0, 8'h11);
    chk("flag_sticky", flag_mismatch, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("flag_cleared", flag_mismatch, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side initiator for the 8-bit combinational ALU. It accepts register-level commands over a valid/ready interface and holds a 4-entry x 8-bit register file. For each command it drives the ALU operand and opcode inputs, then captures the ALU result and zero flag. It writes the result back to the register file and returns a response over a second valid/ready interface. It sits between the command source (test controller or micro-sequencer) and the ALU instance.

Parameters:
DATA_W, 8, operand/result width; must match the ALU.
REG_N, 4, register file entries; the index width is log2(REG_N) = 2.
CNT_W, 16, width of the completed-command counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when high together with cmd_valid.
cmd_load  in  1  1 = load immediate into rd without using the ALU; 0 = ALU operation.
cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT (uses rs1 only), 101-111 illegal.
cmd_rd  in  2  destination register index.
cmd_rs1  in  2  source register for ALU operand A.
cmd_rs2  in  2  source register for ALU operand B.
cmd_imm  in  8  immediate value for load.
alu_a  out  8  to ALU input A.
alu_b  out  8  to ALU input B.
alu_opcode  out  3  to ALU opcode.
alu_out  in  8  from ALU result.
alu_zero  in  1  from ALU zero flag.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accepted.
rsp_data  out  8  result written to rd.
rsp_zero  out  1  zero flag of rsp_data.
rsp_illegal  out  1  command used opcode 101-111.
flag_mismatch  out  1  sticky; set when alu_zero != (alu_out == 0) at capture.
op_count  out  16  saturating count of completed responses.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All register file entries, alu_a, alu_b, alu_opcode, rsp_data, rsp_zero, rsp_illegal, flag_mismatch and op_count are cleared to 0.
  - rsp_valid is 0 and cmd_ready is 0 during the reset cycle.
  - Reset asserted mid-operation discards any in-flight command; no response is produced for it.
- All outputs are registered. cmd_ready = (state == IDLE) and not rst.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, on handshake at edge N:
  - Load command: rf[rd] <= imm; rsp_data <= imm; rsp_zero <= (imm == 0); rsp_illegal <= 0; go to RESP. rsp_valid is high from cycle N+1.
  - ALU command: alu_a <= rf[rs1]; alu_b <= rf[rs2]; alu_opcode <= op; latch rd; rsp_illegal <= (op >= 101); go to ISSUE.
- ISSUE (one cycle): the ALU settles combinationally. At the edge ending the cycle:
  - rf[rd] <= alu_out; rsp_data <= alu_out; rsp_zero <= alu_zero.
  - flag_mismatch |= (alu_zero != (alu_out == 0)).
  - Go to RESP.
  - ALU command latency: handshake at edge N, rsp_valid high from cycle N+2.
- Illegal opcodes are still issued to the ALU. Expected result is 0 with rsp_zero = 1. rsp_illegal = 1.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_zero and rsp_illegal are held stable until the handshake.
  - On rsp_valid && rsp_ready: op_count increments and saturates at 0xFFFF without wrapping; go to IDLE.
  - rsp_ready low stalls indefinitely.
- alu_a, alu_b and alu_opcode hold their last values outside ISSUE.
- Arithmetic is modulo 2^8. The ADD carry and SUB borrow are dropped, matching the ALU.
- rs1 == rs2 == rd is legal. Operands are read before the write-back.
- No new command is accepted until the response handshake completes. Throughput is at most one command per 3 cycles for ALU commands and one per 2 cycles for loads.
- cmd_* inputs are ignored while cmd_ready is 0.
- The register file is internal only; its contents are observable through responses.

Test Plan:
1. Reset, then load r0 = 0x3C and r1 = 0xC4; ADD rd=r2, rs1=r0, rs2=r1 -> rsp_data 0x00, rsp_zero 1, rsp_illegal 0, rsp_valid exactly 2 cycles after the command handshake; op_count = 3.
2. Load r0 = 0x05 and r1 = 0x07; SUB r2 = r0 - r1 -> 0xFE, rsp_zero 0. Then AND r3 = r2 & r1 -> 0x06. OR r3 = r0 | r1 -> 0x07. NOT r0 = ~r0 -> 0xFA.
3. Opcode 110 with rs1 = r1 (0x07) -> rsp_data 0x00, rsp_zero 1, rsp_illegal 1, rf[rd] cleared to 0x00, flag_mismatch stays 0.
4. Hold rsp_ready low for 10 cycles during a response -> rsp_valid and rsp_data stable throughout, cmd_ready 0, a cmd_valid pulse is ignored, op_count unchanged until rsp_ready rises.
5. Assert rst in the ISSUE cycle of an ALU command -> next cycle state IDLE, rsp_valid 0, op_count 0, all registers read back 0x00 via ADD r0 = r0 + r0 -> 0x00.
6. Force alu_zero = 0 while alu_out = 0 in ISSUE -> flag_mismatch rises and stays 1 until rst.
